// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
//   START_ADDR_DEFAULT : default reset PC / memory base
//   NOP_INST           : word handed to decode in place of a faulting fetch
//   fetch_entry_t      : {pc, inst, fault} record carried through the fetch FIFO
//   is_legal_pc        : alignment and range check for a fetch address
package fetch_pkg;

  localparam logic [31:0] START_ADDR_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP_INST           = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fetch_entry_t;

  // Range is checked in 33 bits so a region ending at the top of the address space cannot wrap.
  function automatic logic is_legal_pc(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
    logic [32:0] p;
    logic [32:0] lo;
    logic [32:0] hi;
    p  = {1'b0, pc};
    lo = {1'b0, base};
    hi = lo + {1'b0, size} - 33'd4;
    return (pc[1:0] == 2'b00) && (p >= lo) && (p <= hi);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries between the memory read and decode.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   push       : write wdata this edge (caller guarantees room or a simultaneous pop)
//   pop        : drop the head this edge (caller guarantees non-empty)
//   flush      : discard everything this edge; overrides push and pop
//   wdata      : entry to write
//   rdata      : head entry, all zero when empty
//   count      : number of valid entries
//   empty      : no valid entries
import fetch_pkg::*;

module fetch_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [PtrW:0]   CntOne = (PtrW + 1)'(1);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  fetch_entry_t    mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only visible through rdata, which is masked while empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: drives the memory read port with the PC, captures the returned word
// into a small FIFO and presents {pc, inst, fault} to decode over a valid/ready handshake.
// Ports:
//   clk, rst_n                  : clock and asynchronous active-low reset
//   imem_address                : read address, always the current PC
//   imem_w_enable               : tied low, fetch never writes
//   imem_data_out               : combinational read data for imem_address
//   redirect_valid, redirect_pc : load a new PC and flush everything in flight
//   inst_valid, inst_ready      : handshake for the FIFO head
//   inst_out, inst_pc, inst_fault : head entry fields (zero when empty)
//   halted                      : fetch stopped after a fault until the next redirect
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] START_ADDR = START_ADDR_DEFAULT,
  parameter int unsigned MEM_SIZE   = 1048576,
  parameter int unsigned DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_address,
  output logic        imem_w_enable,
  input  logic [31:0] imem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  output logic        halted
);

  localparam int unsigned     CntW     = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [31:0]     MemSizeW = 32'(MEM_SIZE);

  logic [31:0]     pc_q, pc_d;
  logic            halted_q, halted_d;
  logic            push, pop, flush, pop_req, pc_legal;
  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  fetch_entry_t    wdata, head;

  assign pop_req  = inst_valid && inst_ready;
  assign pc_legal = is_legal_pc(pc_q, START_ADDR, MemSizeW);

  always_comb begin
    pc_d     = pc_q;
    halted_d = halted_q;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    wdata    = '{pc: pc_q, inst: imem_data_out, fault: 1'b0};
    if (redirect_valid) begin
      // Redirect wins: the word being read now and any handshake this edge are dropped.
      flush    = 1'b1;
      pc_d     = redirect_pc;
      halted_d = 1'b0;
    end else begin
      pop = pop_req;
      if (!halted_q && ((fifo_count < DepthCnt) || pop_req)) begin
        push = 1'b1;
        if (pc_legal) begin
          pc_d = pc_q + 32'd4;
        end else begin
          // Fault entry carries a NOP; PC holds so decode sees exactly which address failed.
          wdata.inst  = NOP_INST;
          wdata.fault = 1'b1;
          halted_d    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= START_ADDR;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (pop),
    .flush(flush),
    .wdata(wdata),
    .rdata(head),
    .count(fifo_count),
    .empty(fifo_empty)
  );

  assign imem_address  = pc_q;
  assign imem_w_enable = 1'b0;
  assign inst_valid    = !fifo_empty;
  assign inst_out      = head.inst;
  assign inst_pc       = head.pc;
  assign inst_fault    = head.fault;
  assign halted        = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational memory model.
module tb_fetch_unit;

  localparam logic [31:0] Base = 32'h0100_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_address;
  logic        imem_w_enable;
  logic [31:0] imem_data_out;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .START_ADDR(32'h0100_0000),
    .MEM_SIZE  (1048576),
    .DEPTH     (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_address  (imem_address),
    .imem_w_enable (imem_w_enable),
    .imem_data_out (imem_data_out),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_out      (inst_out),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault),
    .halted        (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word k (from Base) is "addi x(k+1), x0, 5*(k+1)": 0x00500093, 0x00A00113, ...
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] i;
    i = ((a - Base) >> 2) + 32'd1;
    return (((i * 32'd5) & 32'h0000_0fff) << 20) | ((i & 32'd31) << 7) | 32'h0000_0013;
  endfunction

  always_comb imem_data_out = mem_word(imem_address);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc, input logic fault);
    chk({tag, " valid"}, 32'(inst_valid), 32'd1);
    chk({tag, " pc"},    inst_pc, pc);
    chk({tag, " inst"},  inst_out, fault ? 32'h0000_0013 : mem_word(pc));
    chk({tag, " fault"}, 32'(inst_fault), 32'(fault));
  endtask

  initial begin
    rst_n          = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #1 rst_n = 1'b0;
    #1;
    // Reset state
    chk("rst valid",  32'(inst_valid), 32'd0);
    chk("rst addr",   imem_address, Base);
    chk("rst inst",   inst_out, 32'd0);
    chk("rst pc",     inst_pc, 32'd0);
    chk("rst fault",  32'(inst_fault), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst wen",    32'(imem_w_enable), 32'd0);
    step();
    rst_n = 1'b1;
    chk("rel valid", 32'(inst_valid), 32'd0);

    // First fetch one cycle after release
    step();
    chk_head("first", Base, 1'b0);
    chk("first addr", imem_address, Base + 32'd4);

    // Backpressure: fill to two, PC freezes at +8, head stable
    inst_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk_head("stall", Base, 1'b0);
      chk("stall addr", imem_address, Base + 32'd8);
    end
    inst_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk_head("drain", Base + 32'(4 * k), 1'b0);
    end
    chk("drain addr", imem_address, Base + 32'h14);

    // Redirect while full
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0100;
    step();
    redirect_valid = 1'b0;
    chk("redir valid", 32'(inst_valid), 32'd0);
    chk("redir addr",  imem_address, 32'h0100_0100);
    step();
    chk_head("redir tgt", 32'h0100_0100, 1'b0);

    // Misaligned target faults and halts
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0100_0102;
    step();
    redirect_valid = 1'b0;
    chk("mis valid", 32'(inst_valid), 32'd0);
    chk("mis addr",  imem_address, 32'h0100_0102);
    step();
    chk_head("mis fault", 32'h0100_0102, 1'b1);
    chk("mis halted", 32'(halted), 32'd1);
    chk("mis hold",   imem_address, 32'h0100_0102);
    step();
    chk("halt drain", 32'(inst_valid), 32'd0);
    step();
    chk("halt nopush", 32'(inst_valid), 32'd0);
    chk("halt still",  32'(halted), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = Base;
    step();
    redirect_valid = 1'b0;
    chk("unhalt", 32'(halted), 32'd0);
    step();
    chk_head("resume", Base, 1'b0);

    // Run off the end of memory
    redirect_valid = 1'b1;
    redirect_pc    = 32'h010F_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    chk_head("end-8", 32'h010F_FFF8, 1'b0);
    step();
    chk_head("end-4", 32'h010F_FFFC, 1'b0);
    step();
    chk_head("end", 32'h0110_0000, 1'b1);
    chk("end halted", 32'(halted), 32'd1);

    // Async reset with the FIFO holding entries
    redirect_valid = 1'b1;
    redirect_pc    = Base;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    step();
    step();
    chk("pre-rst valid", 32'(inst_valid), 32'd1);
    chk("pre-rst addr",  imem_address, Base + 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid",  32'(inst_valid), 32'd0);
    chk("async addr",   imem_address, Base);
    chk("async pc",     inst_pc, 32'd0);
    chk("async halted", 32'(halted), 32'd0);
    step();
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    step();
    chk_head("restart", Base, 1'b0);
    step();
    chk_head("restart2", Base + 32'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
